// File: rtl/wave_dac_spi.sv
// wave_dac_spi: accepts one 8-bit sample per frame and shifts it out MSB first
// as a 16-bit {CTRL, sample, 4'b0} frame to a serial DAC; samples offered while busy are dropped.
module wave_dac_spi #(
    parameter int         CLK_DIV = 4,
    parameter int         CS_HIGH = 4,
    parameter logic [3:0] CTRL    = 4'b0000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] sample_in,
    input  logic       sample_valid,
    output logic       sample_ready,
    output logic       dac_cs_n,
    output logic       dac_sclk,
    output logic       dac_din,
    output logic       busy,
    output logic       frame_done
);
    localparam int DW = $clog2(2 * CLK_DIV);
    localparam int HW = (CS_HIGH > 1) ? $clog2(CS_HIGH) : 1;
    localparam logic [DW-1:0] DIV_LAST  = DW'(2 * CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF  = DW'(CLK_DIV);
    localparam logic [HW-1:0] HOLD_LAST = HW'(CS_HIGH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t        state_q, state_d;
    logic [15:0]   sh_q, sh_d;
    logic [DW-1:0] div_q, div_d;
    logic [3:0]    bit_q, bit_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          cs_n_q, sclk_q, din_q, busy_q, done_q;

    assign sample_ready = (state_q == IDLE) & rst_n;

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        div_d   = div_q;
        bit_d   = bit_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: if (sample_valid & sample_ready) begin
                state_d = SHIFT;
                sh_d    = {CTRL, sample_in, 4'b0000};
                div_d   = '0;
                bit_d   = '0;
            end
            SHIFT: if (div_q == DIV_LAST) begin
                div_d = '0;
                sh_d  = {sh_q[14:0], 1'b0};
                bit_d = bit_q + 4'd1;
                if (bit_q == 4'd15) begin
                    state_d = HOLD;
                    hold_d  = '0;
                end
            end else begin
                div_d = div_q + 1'b1;
            end
            HOLD: if (hold_q == HOLD_LAST) state_d = IDLE;
                  else hold_d = hold_q + 1'b1;
            default: state_d = IDLE;
        endcase
    end

    // Pin registers are loaded from next-state values so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sh_q    <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            hold_q  <= '0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b0;
            din_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            hold_q  <= hold_d;
            cs_n_q  <= state_d != SHIFT;
            sclk_q  <= (state_d == SHIFT) && (div_d >= DIV_HALF);
            din_q   <= (state_d == SHIFT) && sh_d[15];
            busy_q  <= state_d != IDLE;
            done_q  <= (state_q == SHIFT) && (state_d == HOLD);
        end
    end

    assign dac_cs_n   = cs_n_q;
    assign dac_sclk   = sclk_q;
    assign dac_din    = din_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
endmodule

// File: tb/tb_wave_dac_spi.sv
// tb_wave_dac_spi: table-driven frames plus a per-cycle pin model and a word scoreboard,
// run against a default instance and a fast CLK_DIV=1/CS_HIGH=1/CTRL=1100 instance.
module tb_wave_dac_spi;
    typedef struct {
        int          g;
        logic [7:0]  s;
        bit          ff_after;
        logic [15:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [7:0] sin [2];
    logic sv [2];
    logic ready [2], cs_n [2], sclk [2], din [2], busy [2], done [2];
    int cd [2] = '{4, 1};
    int ch [2] = '{4, 1};
    logic [3:0] ctrl [2] = '{4'b0000, 4'b1100};
    int checks = 0, errs = 0, cyc = 0;
    logic [15:0] exp_q [$];
    logic [7:0] acc_s [$];
    logic [15:0] wexp [2], sh [2], last_word [2];
    int nb [2], acc [2], nacc [2] = '{0, 0};
    int b2b_base [2] = '{0, 0};
    bit active [2], ps [2];
    bit b2b = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    wave_dac_spi u0 (
        .clk(clk), .rst_n(rst_n), .sample_in(sin[0]), .sample_valid(sv[0]),
        .sample_ready(ready[0]), .dac_cs_n(cs_n[0]), .dac_sclk(sclk[0]),
        .dac_din(din[0]), .busy(busy[0]), .frame_done(done[0])
    );
    wave_dac_spi #(.CLK_DIV(1), .CS_HIGH(1), .CTRL(4'b1100)) u1 (
        .clk(clk), .rst_n(rst_n), .sample_in(sin[1]), .sample_valid(sv[1]),
        .sample_ready(ready[1]), .dac_cs_n(cs_n[1]), .dac_sclk(sclk[1]),
        .dac_din(din[1]), .busy(busy[1]), .frame_done(done[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, expv, $time);
        end
    endtask

    // Cycle offsets are counted from the first cycle after the accepting edge.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            int n, off;
            n = 32 * cd[g];
            if (!rst_n) begin
                active[g] = 1'b0;
                nb[g] = 0;
                ps[g] = 1'b0;
                if (g == 0) exp_q.delete();
            end else begin
                if (active[g]) begin
                    off = cyc - acc[g];
                    if (off < n) begin
                        chk("cs_n_low", cs_n[g], 0);
                        chk("sclk", sclk[g], (off % (2 * cd[g])) >= cd[g]);
                        chk("din", din[g], wexp[g][15 - off / (2 * cd[g])]);
                    end else begin
                        chk("cs_n_high", cs_n[g], 1);
                        chk("sclk_hold", sclk[g], 0);
                        chk("din_hold", din[g], 0);
                    end
                    chk("frame_done", done[g], off == n);
                    if (off < n + ch[g]) begin
                        chk("ready_low", ready[g], 0);
                        chk("busy_high", busy[g], 1);
                    end else begin
                        chk("ready_back", ready[g], 1);
                        chk("busy_low", busy[g], 0);
                        active[g] = 1'b0;
                    end
                end else begin
                    chk("idle_cs_n", cs_n[g], 1);
                    chk("idle_done", done[g], 0);
                end
                if (sclk[g] && !ps[g]) begin
                    sh[g] = {sh[g][14:0], din[g]};
                    nb[g]++;
                end
                ps[g] = sclk[g];
                if (done[g]) begin
                    chk("bit_count", nb[g], 16);
                    chk("sb_size", exp_q.size(), 1);
                    if (exp_q.size() > 0) chk("sb_word", sh[g], exp_q.pop_front());
                    last_word[g] = sh[g];
                    nb[g] = 0;
                end
                if (sv[g] && ready[g]) begin
                    if (b2b && nacc[g] >= b2b_base[g])
                        chk("acc_interval", cyc + 1 - acc[g], n + ch[g] + 1);
                    acc[g] = cyc + 1;
                    active[g] = 1'b1;
                    nacc[g]++;
                    wexp[g] = {ctrl[g], sin[g], 4'b0000};
                    exp_q.push_back(wexp[g]);
                    acc_s.push_back(sin[g]);
                    sh[g] = '0;
                    nb[g] = 0;
                end
            end
        end
    end

    task automatic send(input int g, input logic [7:0] s, input bit ff_after);
        int i;
        @(posedge clk); #1;
        for (i = 0; i < 500 && !ready[g]; i++) begin
            @(posedge clk); #1;
        end
        chk("ready_wait", i < 500, 1);
        sin[g] = s;
        sv[g] = 1'b1;
        @(posedge clk); #1;
        sv[g] = 1'b0;
        if (ff_after) sin[g] = 8'hFF;
    endtask

    task automatic wait_frame(input int g);
        int i;
        for (i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (done[g]) break;
        end
        chk("done_timeout", i < 2000, 1);
        for (i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ready[g]) break;
        end
        chk("idle_timeout", i < 100, 1);
        #1;
    endtask

    task automatic chk_reset_pins(input string tag);
        for (int g = 0; g < 2; g++) begin
            chk({tag, "_cs_n"}, cs_n[g], 1);
            chk({tag, "_sclk"}, sclk[g], 0);
            chk({tag, "_din"}, din[g], 0);
            chk({tag, "_busy"}, busy[g], 0);
            chk({tag, "_done"}, done[g], 0);
            chk({tag, "_ready"}, ready[g], 0);
        end
    endtask

    initial begin
        vec_t tbl [5];
        int s0, i;
        tbl[0] = '{0, 8'hA5, 1'b0, 16'h0A50};
        tbl[1] = '{0, 8'h3C, 1'b1, 16'h03C0};
        tbl[2] = '{0, 8'hFF, 1'b0, 16'h0FF0};
        tbl[3] = '{0, 8'h00, 1'b0, 16'h0000};
        tbl[4] = '{1, 8'h81, 1'b0, 16'hC810};
        sin[0] = '0; sin[1] = '0; sv[0] = 1'b0; sv[1] = 1'b0;
        #3 rst_n = 1'b0;
        #1 chk_reset_pins("rst");
        repeat (3) @(posedge clk);
        @(negedge clk); #2 rst_n = 1'b1;
        #1 chk("ready_after_rst0", ready[0], 1);
        chk("ready_after_rst1", ready[1], 1);

        for (int k = 0; k < 5; k++) begin
            send(tbl[k].g, tbl[k].s, tbl[k].ff_after);
            wait_frame(tbl[k].g);
            chk("tbl_word", last_word[tbl[k].g], tbl[k].exp);
        end

        // Back-to-back on the default instance with an incrementing sample stream.
        s0 = acc_s.size();
        b2b_base[0] = nacc[0] + 1;
        b2b = 1'b1;
        @(posedge clk); #1;
        sin[0] = 8'h00;
        sv[0] = 1'b1;
        for (i = 0; i < 600 && nacc[0] < b2b_base[0] + 2; i++) begin
            @(posedge clk); #1;
            sin[0] = sin[0] + 8'd1;
        end
        sv[0] = 1'b0;
        chk("b2b_timeout", i < 600, 1);
        wait_frame(0);
        chk("b2b_count", acc_s.size(), s0 + 3);
        if (acc_s.size() >= s0 + 3) begin
            chk("b2b_s0", acc_s[s0], 8'h00);
            chk("b2b_s1", acc_s[s0 + 1], 8'h85);
            chk("b2b_s2", acc_s[s0 + 2], 8'h0A);
        end

        // Fast instance: two back-to-back frames give a 34-cycle accept interval.
        b2b_base[1] = nacc[1] + 1;
        @(posedge clk); #1;
        sin[1] = 8'h81;
        sv[1] = 1'b1;
        for (i = 0; i < 200 && nacc[1] < b2b_base[1] + 1; i++) begin
            @(posedge clk); #1;
        end
        sv[1] = 1'b0;
        chk("fast_timeout", i < 200, 1);
        wait_frame(1);
        chk("fast_word", last_word[1], 16'hC810);
        b2b = 1'b0;

        // Abort a frame after the seventh rising sclk.
        send(0, 8'h77, 1'b0);
        for (i = 0; i < 1000 && nb[0] < 7; i++) @(posedge clk);
        chk("abort_wait", nb[0], 7);
        @(negedge clk); #2 rst_n = 1'b0;
        #1 chk_reset_pins("abort");
        repeat (6) begin
            @(negedge clk); #1;
            chk("abort_sclk", sclk[0], 0);
            chk("abort_done", done[0], 0);
            chk("abort_cs_n", cs_n[0], 1);
        end
        #1 rst_n = 1'b1;
        #1 chk("abort_ready", ready[0], 1);
        send(0, 8'h5A, 1'b0);
        wait_frame(0);
        chk("after_abort_word", last_word[0], 16'h05A0);

        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, %0d failures so far", errs);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/wave_dac_spi.md
# wave_dac_spi

Serial DAC driver sitting directly downstream of the waveform generator. It takes the generator's 8-bit sample stream through a valid/ready handshake and shifts each accepted sample out as a 16-bit SPI-style frame (chip select, serial clock, data) to an external 8-bit serial DAC. The generator produces a sample every clk. This block accepts one sample per frame and drops samples offered while it is busy, so the DAC update rate is set by the frame period.

## Interface
- CLK_DIV, 4: clk cycles per dac_sclk half-period; legal range ≥1.
- CS_HIGH, 4: clk cycles dac_cs_n is held high between frames; legal range ≥1.
- CTRL, 4'b0000: control nibble placed in frame bits [15:12].
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- sample_in  input  8  sample from the waveform generator; captured only at accept.
- sample_valid  input  1  sample_in is valid.
- sample_ready  output  1  block can accept a sample; = (state==IDLE) & rst_n (combinational).
- dac_cs_n  output  1  DAC chip select, active-low, registered.
- dac_sclk  output  1  DAC serial clock, registered.
- dac_din  output  1  DAC serial data, MSB first, registered.
- busy  output  1  high whenever state != IDLE, registered.
- frame_done  output  1  one-cycle pulse when a frame completes, registered.

## Operation
- Frame word: {CTRL[3:0], sample[7:0], 4'b0000}, shifted out MSB first (bit 15 first).
- States:
  - IDLE: cs_n=1, sclk=0, din=0, ready=1. If sample_valid & sample_ready at a clk edge, the block latches the frame word into the shift register, clears the divider and bit counters, and goes to SHIFT.
  - SHIFT: 16 bit periods of 2*CLK_DIV cycles each. In each bit period, sclk=0 for the first CLK_DIV cycles and sclk=1 for the last CLK_DIV cycles. At the end of a bit period the register shifts left, so din changes coincident with the falling sclk. The DAC samples on the rising sclk. After bit 15 (bit counter wraps 15->0), go to HOLD.
  - HOLD: cs_n=1, sclk=0, din=0 for CS_HIGH cycles, then return to IDLE. frame_done is high during the first HOLD cycle only.
- din holds frame[15-k] for the whole of bit period k.
- Counters:
  - Divider counter: ceil(log2(2*CLK_DIV)) bits.
  - Bit counter: 4 bits.
  - Hold counter: sized for CS_HIGH.
  - No counter wraps except the bit counter at the frame end.
- There is no queueing. sample_valid while busy is ignored, and the sample is lost. Changes on sample_in after accept do not affect the frame in flight.
- Reset (asynchronous, including mid-frame):
  - Immediately: state=IDLE, dac_cs_n=1, dac_sclk=0, dac_din=0, busy=0, frame_done=0.
  - The partial frame is discarded, and no frame_done is issued for it.

## Timing
- Reset values: dac_cs_n=1, dac_sclk=0, dac_din=0, busy=0, frame_done=0. sample_ready=0 while rst_n is low.
- Accept at edge T (end of cycle T). Let N = 32*CLK_DIV.
  - Cycles T+1 .. T+N: dac_cs_n=0, busy=1, sample_ready=0. dac_din=bit15 from cycle T+1.
  - First rising dac_sclk in cycle T+1+CLK_DIV. 16 rising edges total.
  - Cycle T+N+1: dac_cs_n=1 and frame_done=1.
  - HOLD spans cycles T+N+1 .. T+N+CS_HIGH.
  - Cycle T+N+CS_HIGH+1: IDLE, sample_ready=1.
- Minimum accept-to-accept interval = N+CS_HIGH+1 cycles. Defaults: cs_n low for 128 cycles, period 133 cycles.
- CLK_DIV=1: dac_sclk = clk/2, and cs_n is low for 32 cycles.
- sample_valid held permanently high (normal use): an accept occurs at the first edge of every IDLE cycle, with no gap cycle.

## Test plan
- Reset: assert rst_n low mid-simulation. Required: dac_cs_n=1, dac_sclk=0, dac_din=0, busy=0, frame_done=0, sample_ready=0 immediately (no clk edge needed). After release, sample_ready=1.
- Single frame, defaults, sample_in=8'hA5 for one valid cycle. Required:
  - dac_din sampled on the 16 dac_sclk rising edges gives 16'h0A50.
  - dac_cs_n low for exactly 128 cycles.
  - frame_done a single pulse in cycle T+129.
  - sample_ready back high at T+133.
- Back-to-back: sample_valid held high, with sample_in incrementing each cycle from 8'h00. Required:
  - Accepts exactly 133 cycles apart.
  - Transmitted samples are 8'h00, 8'h85, 8'h0A (values present at each accept edge).
  - sample_ready=0 throughout every frame.
- Input stability: accept 8'h3C, then drive sample_in=8'hFF for the rest of the frame. Required: the shifted word is still 16'h03C0.
- Reset mid-frame: assert rst_n after the 7th rising dac_sclk. Required:
  - dac_cs_n=1 immediately, with no further sclk edges and no frame_done.
  - The next frame of 8'h5A after release shifts 16'h05A0 cleanly.
- Parameters CLK_DIV=1, CS_HIGH=1, CTRL=4'b1100, sample 8'h81. Required:
  - dac_sclk period 2 cycles.
  - dac_cs_n low 32 cycles.
  - Shifted word 16'hC810.
  - Accept-to-accept interval 34 cycles.
